packed_not_pipe: RTL

Parametrised, buffered successor to the single-gate packed-array inverter.
- Accepts a packed 3-D vector [ROWS][COLS][ELEM_W] over a valid/ready handshake.
- Applies a per-beat selectable transform over the full width, with no truncation to 1 bit.
- Stores results in a DEPTH-entry FIFO and drains them over a second valid/ready handshake.
- Sits between packed-array producers and consumers that need element-wise inversion or reduction with backpressure.

---
 rtl/packed_not_pkg.sv | 16 +
 rtl/packed_not_xform.sv | 29 ++
 rtl/packed_not_pipe.sv | 88 ++++++++
 3 files changed

// File: rtl/packed_not_pkg.sv
// Shared types and default dimensions for the packed-array transform pipe.
package packed_not_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_NOT  = 2'b01,
    MODE_RNOR = 2'b10,
    MODE_ONES = 2'b11
  } mode_e;

  localparam int DEF_ROWS   = 5;
  localparam int DEF_COLS   = 4;
  localparam int DEF_ELEM_W = 3;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/packed_not_xform.sv
// Combinational element-wise transform over a packed [ROWS][COLS][ELEM_W] vector.
module packed_not_xform
  import packed_not_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ELEM_W = DEF_ELEM_W
) (
  input  mode_e                                  mode_i,
  input  logic [0:ROWS-1][COLS-1:0][1:ELEM_W]    vec_i,
  output logic [0:ROWS-1][COLS-1:0][1:ELEM_W]    vec_o
);

  always_comb begin
    vec_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        unique case (mode_i)
          MODE_PASS: vec_o[r][c] = vec_i[r][c];
          MODE_NOT:  vec_o[r][c] = ~vec_i[r][c];
          // Index 1 is the element MSB; the reduction lands there, rest stays 0.
          MODE_RNOR: vec_o[r][c][1] = ~|vec_i[r][c];
          default:   vec_o[r][c] = '1;
        endcase
      end
    end
  end

endmodule

// File: rtl/packed_not_pipe.sv
// Transform-on-accept front end feeding a DEPTH-entry FIFO with valid/ready on both sides.
module packed_not_pipe
  import packed_not_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [1:0]                             mode_i,
  input  logic                                   flush_i,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [0:ROWS-1][COLS-1:0][1:ELEM_W]    in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [0:ROWS-1][COLS-1:0][1:ELEM_W]    out_data,
  output logic [$clog2(DEPTH+1)-1:0]             count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef logic [0:ROWS-1][COLS-1:0][1:ELEM_W] vec_t;

  vec_t          mem_q [DEPTH];
  vec_t          xf_data;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  packed_not_xform #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ELEM_W (ELEM_W)
  ) u_xform (
    .mode_i (mode_e'(mode_i)),
    .vec_i  (in_data),
    .vec_o  (xf_data)
  );

  // Ready depends only on registered occupancy, so a full FIFO never accepts
  // even when the head drains in the same cycle.
  assign in_ready  = (cnt_q < DEPTH_C) && !flush_i;
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign count_o   = cnt_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push) mem_q[wr_q] <= xf_data;
    end
  end

endmodule
